nonce_uart_sender: RTL and testbench
====================================

// Module: nonce_uart_sender
// PURPOSE
//  Queues solution nonces from the hash cores and serialises each one into
//  bytes for the downstream UART transmitter (8N1 async_transmitter).
//  Drives the transmitter's start/data inputs and obeys its busy flag.
//  It sits between the nonce-found logic and the UART TX pin.
// PARAMETERS
//  NONCE_W     64  nonce width in bits; must be a multiple of 8
//  FIFO_DEPTH  4   nonces buffered; power of 2, >= 2
//  SYNC_BYTE   8'hA5  header byte sent before every nonce
// PORTS
//  clk          in   1        system clock
//  rst_n        in   1        asynchronous active-low reset
//  nonce_valid  in   1        one-cycle strobe: nonce_in is a solution
//  nonce_in     in   NONCE_W  solution nonce
//  tx_busy      in   1        from transmitter TxD_busy
//  tx_start     out  1        to transmitter TxD_start; one-cycle pulse
//  tx_data      out  8        to transmitter TxD_data; valid while tx_start=1
//  fifo_level   out  $clog2(FIFO_DEPTH)+1  nonces queued, excluding the one in flight
//  drop_cnt     out  8        nonces lost to overflow; saturates at 8'hFF
//  sending      out  1        high from the frame load to the end of the last byte
// BEHAVIOUR
//  Reset values
//   - All outputs are 0; FIFO is empty; FSM is in IDLE.
//   - Reset mid-frame abandons the frame with no partial flush.
//  FIFO
//   - Synchronous FIFO with wrapping read/write pointers.
//   - Push on nonce_valid when not full.
//   - Push while full is accepted only if a pop occurs in the same cycle.
//     Otherwise the nonce is dropped and drop_cnt increments; it holds at 255.
//   - Simultaneous push and pop leaves fifo_level unchanged.
//  Frame format
//   - Frame = SYNC_BYTE, then NONCE_W/8 nonce bytes, most-significant byte first.
//   - 64-bit default gives 9 bytes per frame.
//  FSM states: IDLE, LOAD, START, WAIT_HI, WAIT_LO
//   - IDLE: if the FIFO is not empty, pop into the shift register and go to LOAD.
//     Set byte_idx=0; sending rises on that edge.
//   - LOAD: tx_data <= byte[byte_idx] (idx 0 = SYNC_BYTE). Go to START.
//   - START: if tx_busy=0, assert tx_start for exactly 1 cycle and go to WAIT_HI.
//     Otherwise hold in START.
//   - WAIT_HI: wait for tx_busy=1. The transmitter raises it 1 cycle after start.
//     Timeout after 4 cycles goes to WAIT_LO regardless, to avoid a deadlock.
//   - WAIT_LO: wait for tx_busy=0.
//     If byte_idx is the last byte: clear sending, go to IDLE.
//     Otherwise byte_idx++ and go to LOAD.
//  Timing rules
//   - tx_data changes only in LOAD and is held stable through WAIT_LO.
//   - tx_start is never asserted while tx_busy=1.
//   - Back-to-back frames: IDLE re-pops on the cycle after the last WAIT_LO.
//     There is no inter-frame gap beyond the FSM cycles.
//   - Latency: nonce_valid into an empty FIFO while IDLE gives tx_start 3 cycles later.
//     Cycle 1: FIFO write. Cycle 2: pop (IDLE->LOAD). Cycle 3: tx_start (START).
//   - Byte counter width: $clog2(NONCE_W/8+1). Only indices 0..NONCE_W/8 are used.
// TESTING (bench pairs this block with async_transmitter, Baud reduced for sim)
//  1. nonce_in=64'h0123456789ABCDEF strobe.
//     -> UART line decodes A5 01 23 45 67 89 AB CD EF; drop_cnt=0; sending falls after the stop bit.
//  2. 4 strobes in consecutive cycles while IDLE.
//     -> 1 popped immediately, fifo_level peaks at 3; 4 frames go out in order; no drops.
//  3. 7 strobes while the first frame is sending (DEPTH=4).
//     -> fifo_level=4, drop_cnt=2; 5 frames total transmitted.
//  4. Strobe on the same cycle the FSM pops with the FIFO full.
//     -> push accepted, fifo_level stays 4, drop_cnt unchanged.
//  5. Assert rst_n=0 during byte 4 of a frame.
//     -> tx_start=0, fifo_level=0, sending=0 immediately.
//     After release, a new strobe produces a full, correct frame.
//  6. Hold tx_busy=1 externally for 100 cycles.
//     -> FSM stays in START, no tx_start pulse; sends once busy drops.

Source files
------------

// File: rtl/nonce_uart_sender.sv
// Buffers solution nonces in a small FIFO and streams each one as a framed
// byte sequence (sync byte, then nonce MSB first) into an 8N1 UART transmitter.
module nonce_uart_sender #(
  parameter int unsigned NONCE_W    = 64,
  parameter int unsigned FIFO_DEPTH = 4,
  parameter logic [7:0]  SYNC_BYTE  = 8'hA5
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            nonce_valid,
  input  logic [NONCE_W-1:0]              nonce_in,
  input  logic                            tx_busy,
  output logic                            tx_start,
  output logic [7:0]                      tx_data,
  output logic [$clog2(FIFO_DEPTH):0]     fifo_level,
  output logic [7:0]                      drop_cnt,
  output logic                            sending
);

  localparam int unsigned BYTES = NONCE_W / 8;
  localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
  localparam int unsigned LVL_W = PTR_W + 1;
  localparam int unsigned IDX_W = $clog2(BYTES + 1);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(BYTES);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_START,
    S_WAIT_HI,
    S_WAIT_LO
  } state_e;

  // ---------------------------------------------------------------- FIFO
  logic [NONCE_W-1:0] mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0]   wr_ptr_q, rd_ptr_q;
  logic [LVL_W-1:0]   level_q;
  logic [7:0]         drop_cnt_q;
  logic               fifo_full, fifo_empty;
  logic               push, pop, drop;

  state_e state_q, state_d;

  assign fifo_full  = (level_q == LVL_W'(FIFO_DEPTH));
  assign fifo_empty = (level_q == '0);
  assign pop        = (state_q == S_IDLE) && !fifo_empty;
  // A full FIFO still takes a nonce when the slot is freed in the same cycle.
  assign push       = nonce_valid && (!fifo_full || pop);
  assign drop       = nonce_valid && fifo_full && !pop;

  // NOTE: storage has no reset; validity is tracked by the pointers and level.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= nonce_in;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of process ordering.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      level_q    <= '0;
      drop_cnt_q <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({push, pop})
        2'b10:   level_q <= level_q + 1'b1;
        2'b01:   level_q <= level_q - 1'b1;
        default: level_q <= level_q;
      endcase
      if (drop && (drop_cnt_q != 8'hFF)) begin
        drop_cnt_q <= drop_cnt_q + 8'd1;
      end
    end
  end

  // ---------------------------------------------------------------- framer
  logic [NONCE_W-1:0] shift_q, shift_d;
  logic [IDX_W-1:0]   byte_idx_q, byte_idx_d;
  logic [7:0]         tx_data_q, tx_data_d;
  logic               sending_q, sending_d;
  logic [1:0]         tmo_q, tmo_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      shift_q    <= '0;
      byte_idx_q <= '0;
      tx_data_q  <= '0;
      sending_q  <= 1'b0;
      tmo_q      <= '0;
    end else begin
      state_q    <= state_d;
      shift_q    <= shift_d;
      byte_idx_q <= byte_idx_d;
      tx_data_q  <= tx_data_d;
      sending_q  <= sending_d;
      tmo_q      <= tmo_d;
    end
  end

  // NOTE: every signal assigned here gets a default first, so no path can
  // leave one unassigned and infer a latch.
  always_comb begin
    state_d    = state_q;
    shift_d    = shift_q;
    byte_idx_d = byte_idx_q;
    tx_data_d  = tx_data_q;
    sending_d  = sending_q;
    tmo_d      = tmo_q;
    tx_start   = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (pop) begin
          shift_d    = mem_q[rd_ptr_q];
          byte_idx_d = '0;
          sending_d  = 1'b1;
          state_d    = S_LOAD;
        end
      end
      S_LOAD: begin
        // Index 0 is the header; later indices consume the nonce MSB first.
        if (byte_idx_q == '0) begin
          tx_data_d = SYNC_BYTE;
        end else begin
          tx_data_d = shift_q[NONCE_W-1 -: 8];
          shift_d   = shift_q << 8;
        end
        state_d = S_START;
      end
      S_START: begin
        if (!tx_busy) begin
          tx_start = 1'b1;
          tmo_d    = '0;
          state_d  = S_WAIT_HI;
        end
      end
      S_WAIT_HI: begin
        // Give up waiting for busy after four cycles so a silent transmitter
        // cannot hang the framer.
        if (tx_busy || (tmo_q == 2'd3)) begin
          state_d = S_WAIT_LO;
        end else begin
          tmo_d = tmo_q + 2'd1;
        end
      end
      S_WAIT_LO: begin
        if (!tx_busy) begin
          if (byte_idx_q == LAST_IDX) begin
            sending_d = 1'b0;
            state_d   = S_IDLE;
          end else begin
            byte_idx_d = byte_idx_q + 1'b1;
            state_d    = S_LOAD;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign tx_data    = tx_data_q;
  assign fifo_level = level_q;
  assign drop_cnt   = drop_cnt_q;
  assign sending    = sending_q;

endmodule

// File: tb/tb_nonce_uart_sender.sv
// Randomised bench for nonce_uart_sender: a behavioural transmitter plus a
// frame-level reference model predicting bytes, start cycles, level and drops.
module tb_nonce_uart_sender;

  localparam int NONCE_W     = 64;
  localparam int DEPTH       = 4;
  localparam int BYTES       = NONCE_W / 8;
  localparam int BIT_CYC     = 10;                  // transmitter busy length per byte
  localparam int BYTE_PERIOD = BIT_CYC + 3;         // load, start, wait-hi, busy, release
  localparam int FRAME       = 1 + (BYTES + 1) * BYTE_PERIOD;

  logic               clk = 1'b0;
  logic               rst_n = 1'b0;
  logic               nonce_valid = 1'b0;
  logic [NONCE_W-1:0] nonce_in = '0;
  logic               tx_busy = 1'b0;
  logic               tx_start;
  logic [7:0]         tx_data;
  logic [2:0]         fifo_level;
  logic [7:0]         drop_cnt;
  logic               sending;

  always #5 clk = ~clk;

  nonce_uart_sender #(
    .NONCE_W   (NONCE_W),
    .FIFO_DEPTH(DEPTH),
    .SYNC_BYTE (8'hA5)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .nonce_valid(nonce_valid),
    .nonce_in   (nonce_in),
    .tx_busy    (tx_busy),
    .tx_start   (tx_start),
    .tx_data    (tx_data),
    .fifo_level (fifo_level),
    .drop_cnt   (drop_cnt),
    .sending    (sending)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference model state
  logic [NONCE_W-1:0] q[$];
  logic [7:0]         exp_bytes[$];
  longint             exp_start[$];
  logic [7:0]         cap[$];
  longint             cyc = 0;
  longint             frame_end = 0;
  int                 drops = 0;
  int                 exp_level = 0;
  bit                 exp_sending = 1'b0;
  int                 busy_cnt = 0;
  bit                 hold_busy = 1'b0;
  bit                 timing_ok = 1'b1;
  int                 n_starts = 0;

  function automatic int exp_drop();
    return (drops > 255) ? 255 : drops;
  endfunction

  task automatic model_edge(input bit v, input logic [NONCE_W-1:0] d);
    logic [NONCE_W-1:0] n;
    if (cyc >= frame_end && q.size() > 0) begin
      n = q.pop_front();
      exp_bytes.push_back(8'hA5);
      for (int k = BYTES - 1; k >= 0; k--) exp_bytes.push_back(n[8*k +: 8]);
      for (int k = 0; k <= BYTES; k++) exp_start.push_back(cyc + 2 + k * BYTE_PERIOD);
      frame_end = cyc + FRAME;
    end
    if (v) begin
      if (q.size() < DEPTH) q.push_back(d);
      else drops++;
    end
    exp_level   = q.size();
    exp_sending = (cyc + 1 < frame_end);
  endtask

  // One clock cycle: drive inputs mid-cycle, check outputs, run transmitter and model.
  task automatic step(input bit v, input logic [NONCE_W-1:0] d);
    longint t;
    @(negedge clk);
    cyc++;
    tx_busy = hold_busy || (busy_cnt > 0);
    if (busy_cnt > 0) busy_cnt--;
    nonce_valid = v;
    nonce_in    = d;
    #1;
    check("fifo_level", fifo_level, exp_level);
    check("drop_cnt", drop_cnt, exp_drop());
    if (timing_ok) check("sending", sending, exp_sending);
    if (tx_start) begin
      n_starts++;
      check("start_while_busy", tx_busy, 0);
      check("start_expected", exp_bytes.size() > 0, 1);
      if (exp_bytes.size() > 0) begin
        cap.push_back(tx_data);
        check("tx_byte", tx_data, exp_bytes.pop_front());
        t = exp_start.pop_front();
        if (timing_ok) check("start_cycle", cyc, t);
      end
      busy_cnt = BIT_CYC;
    end
    model_edge(v, d);
  endtask

  task automatic drain(input int budget);
    int k = 0;
    while ((q.size() > 0 || cyc + 1 < frame_end || exp_bytes.size() > 0) && k < budget) begin
      step(1'b0, '0);
      k++;
    end
    step(1'b0, '0);
    check("drain_bytes_left", exp_bytes.size(), 0);
    check("drain_level", fifo_level, 0);
    check("drain_sending", sending, 0);
  endtask

  logic [7:0] golden [9] = '{8'hA5, 8'h01, 8'h23, 8'h45, 8'h67, 8'h89, 8'hAB, 8'hCD, 8'hEF};

  initial begin
    int d0, s0, k;
    // Reset state
    repeat (2) @(negedge clk);
    #1;
    check("rst_tx_start", tx_start, 0);
    check("rst_tx_data", tx_data, 0);
    check("rst_fifo_level", fifo_level, 0);
    check("rst_drop_cnt", drop_cnt, 0);
    check("rst_sending", sending, 0);
    @(negedge clk);
    rst_n = 1'b1;

    // Single known nonce: frame content and 3-cycle latency
    cap.delete();
    step(1'b1, 64'h0123456789ABCDEF);
    drain(400);
    check("t1_frame_len", cap.size(), 9);
    for (int i = 0; i < 9; i++) begin
      if (i < cap.size()) check("t1_byte", cap[i], golden[i]);
    end
    check("t1_drops", drop_cnt, 0);

    // Four consecutive strobes from idle
    for (int i = 0; i < 4; i++) step(1'b1, {$urandom, $urandom});
    step(1'b0, '0);
    check("t2_peak_level", fifo_level, 3);
    drain(1000);
    check("t2_drops", drop_cnt, 0);

    // Seven strobes: overflow, then a strobe coinciding with a full-FIFO pop
    d0 = exp_drop();
    s0 = n_starts;
    for (int i = 0; i < 7; i++) step(1'b1, {$urandom, $urandom});
    step(1'b0, '0);
    check("t3_level_full", fifo_level, 4);
    check("t3_drops", drop_cnt, d0 + 2);
    k = 0;
    while (cyc + 1 < frame_end && k < 400) begin
      step(1'b0, '0);
      k++;
    end
    step(1'b1, {$urandom, $urandom});
    step(1'b0, '0);
    check("t4_level_held", fifo_level, 4);
    check("t4_drops_held", drop_cnt, d0 + 2);
    drain(1500);
    check("t34_frames", n_starts - s0, 6 * (BYTES + 1));

    // Random traffic
    for (int i = 0; i < 1500; i++) begin
      step($urandom_range(0, 99) < 3, {$urandom, $urandom});
    end
    drain(1500);

    // Drop counter saturation
    for (int i = 0; i < 300; i++) step(1'b1, {$urandom, $urandom});
    check("sat_drop_cnt", drop_cnt, 255);
    drain(1500);

    // Transmitter holds busy: no start until it drops
    hold_busy = 1'b1;
    timing_ok = 1'b0;
    s0 = n_starts;
    step(1'b1, {$urandom, $urandom});
    for (int i = 0; i < 100; i++) step(1'b0, '0);
    check("hold_no_start", n_starts, s0);
    hold_busy = 1'b0;
    k = 0;
    while ((exp_bytes.size() > 0 || sending) && k < 1000) begin
      step(1'b0, '0);
      k++;
    end
    check("hold_frame_sent", n_starts - s0, BYTES + 1);
    check("hold_sending_low", sending, 0);
    frame_end   = cyc;
    exp_sending = 1'b0;
    exp_start.delete();
    timing_ok   = 1'b1;

    // Reset in the middle of byte 4
    s0 = n_starts;
    step(1'b1, {$urandom, $urandom});
    k = 0;
    while (n_starts < s0 + 4 && k < 200) begin
      step(1'b0, '0);
      k++;
    end
    check("mid_reached_byte4", n_starts, s0 + 4);
    step(1'b1, {$urandom, $urandom});
    step(1'b1, {$urandom, $urandom});
    step(1'b0, '0);
    @(negedge clk);
    nonce_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    check("mid_rst_tx_start", tx_start, 0);
    check("mid_rst_level", fifo_level, 0);
    check("mid_rst_sending", sending, 0);
    check("mid_rst_drop_cnt", drop_cnt, 0);
    q.delete();
    exp_bytes.delete();
    exp_start.delete();
    drops = 0;
    exp_level = 0;
    exp_sending = 1'b0;
    busy_cnt = 0;
    tx_busy = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    cyc += 3;
    frame_end = 0;
    cap.delete();
    step(1'b1, 64'hFEDCBA9876543210);
    drain(400);
    check("post_rst_frame_len", cap.size(), BYTES + 1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #500_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog expired");
  end

endmodule
